// File: rtl/isa_test_monitor.sv
// Watches command channels for a store to the to-host completion address, then
// waits a settle window and snapshots the core's test verdict and counters.
module isa_test_monitor #(
   parameter int                    CHN_N          = 2,
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] TO_HOST_ADDR   = ADDR_WIDTH'(32'h3000),
   parameter int                    SETTLE_CYCLES  = 10,
   parameter int                    TIMEOUT_CYCLES = 0,
   parameter int                    CNT_WIDTH      = 32,
   parameter int                    SIM_DELAY      = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [CHN_N*ADDR_WIDTH-1:0] cmd_addr,
   input  logic [CHN_N-1:0]            cmd_valid,
   input  logic [CHN_N-1:0]            cmd_ready,
   input  logic [31:0]                 test_num,
   input  logic [31:0]                 minstret,
   input  logic [31:0]                 mcycle,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic                        fail,
   output logic                        timeout,
   output logic [1:0]                  hit_chn,
   output logic [31:0]                 fail_testnum,
   output logic [31:0]                 minstret_snap,
   output logic [31:0]                 mcycle_snap,
   output logic [CNT_WIDTH-1:0]        elapsed
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam bit                  TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Reject configurations the logic below cannot represent.
   if (CHN_N < 1 || CHN_N > 4 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 0 ||
       CNT_WIDTH < 1 || SIM_DELAY < 0) begin : g_bad_params
      $error("isa_test_monitor: illegal parameter value");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      SETTLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   logic [SET_W-1:0] settle_cnt;
   logic             hit_any_c;
   logic [1:0]       hit_idx_c;

   // Descending scan so the lowest hitting channel is the one left standing.
   always_comb begin
      hit_any_c = 1'b0;
      hit_idx_c = 2'd0;
      for (int i = CHN_N - 1; i >= 0; i--) begin
         if (cmd_valid[i] && cmd_ready[i] &&
             cmd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == TO_HOST_ADDR) begin
            hit_any_c = 1'b1;
            hit_idx_c = 2'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         settle_cnt    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         fail          <= 1'b0;
         timeout       <= 1'b0;
         hit_chn       <= 2'd0;
         fail_testnum  <= 32'd0;
         minstret_snap <= 32'd0;
         mcycle_snap   <= 32'd0;
         elapsed       <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= RUN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  pass    <= 1'b0;
                  fail    <= 1'b0;
                  timeout <= 1'b0;
                  elapsed <= '0;
               end
            end
            RUN: begin
               if (elapsed != CNT_MAX) begin
                  elapsed <= elapsed + CNT_WIDTH'(1);
               end
               // A hit on the limit cycle wins over the timeout.
               if (hit_any_c) begin
                  state      <= SETTLE;
                  settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                  hit_chn    <= hit_idx_c;
               end else if (TO_EN && elapsed == TO_LAST) begin
                  state         <= DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  timeout       <= 1'b1;
                  fail          <= 1'b1;
                  pass          <= 1'b0;
                  fail_testnum  <= test_num;
                  minstret_snap <= minstret;
                  mcycle_snap   <= mcycle;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state         <= DONE;
                  busy          <= 1'b0;
                  done          <= 1'b1;
                  pass          <= (test_num == 32'd1);
                  fail          <= (test_num != 32'd1);
                  fail_testnum  <= test_num;
                  minstret_snap <= minstret;
                  mcycle_snap   <= mcycle;
               end else begin
                  settle_cnt <= settle_cnt - SET_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
